// File: rtl/key_beep_seq_if.sv
// key_beep_seq_if: bundles the key/mode inputs and buzzer status outputs of
// the key_beep_seq buzzer sequencer.
//   key_filter [KEY_NUM-1:0] : debounced active-low keys (master -> slave)
//   mode                     : 0 = toggle, 1 = burst  (master -> slave)
//   beep                     : buzzer drive           (slave -> master)
//   busy                     : burst in progress      (slave -> master)
//   key_id     [KID_W-1:0]   : last accepted key      (slave -> master)
interface key_beep_seq_if #(
    parameter int KEY_NUM = 4
) ();
    localparam int KID_W = (KEY_NUM > 1) ? $clog2(KEY_NUM) : 1;

    logic [KEY_NUM-1:0] key_filter;
    logic               mode;
    logic               beep;
    logic               busy;
    logic [KID_W-1:0]   key_id;

    modport master (
        output key_filter,
        output mode,
        input  beep,
        input  busy,
        input  key_id
    );

    modport slave (
        input  key_filter,
        input  mode,
        output beep,
        output busy,
        output key_id
    );
endinterface

// File: rtl/key_beep_seq.sv
// key_beep_seq: multi-key buzzer sequencer.
// Toggle mode: any accepted press flips the buzzer on/off.
// Burst mode : key i plays i+1 beeps of ON_CYC clocks separated by OFF_CYC.
// TONE_DIV = 0 drives an active buzzer with a level; TONE_DIV > 0 produces a
// square wave toggling every TONE_DIV clocks while sounding.
// Ports:
//   sys_clk   : system clock
//   sys_rst_n : synchronous active-low reset
//   bus       : key_beep_seq_if slave (key_filter, mode in; beep, busy, key_id out)
// All outputs are registers; their next values are computed combinationally
// from the next FSM state so a press is visible one cycle after the key edge.
module key_beep_seq #(
    parameter int KEY_NUM  = 4,
    parameter int ON_CYC   = 10_000_000,
    parameter int OFF_CYC  = 5_000_000,
    parameter int TONE_DIV = 0
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    key_beep_seq_if.slave bus
);
    localparam int KID_W   = (KEY_NUM > 1) ? $clog2(KEY_NUM) : 1;
    localparam int MAX_CYC = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int REM_W   = $clog2(KEY_NUM + 1);
    localparam int TDIV_W  = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

    localparam logic [CNT_W-1:0]  ON_LAST   = CNT_W'(ON_CYC - 1);
    localparam logic [CNT_W-1:0]  OFF_LAST  = CNT_W'(OFF_CYC - 1);
    localparam logic [TDIV_W-1:0] TDIV_LAST = TDIV_W'(TONE_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    state_t              state_r, state_s;
    logic [KEY_NUM-1:0]  key_d0_r;
    logic [CNT_W-1:0]    cnt_r, cnt_s;
    logic [REM_W-1:0]    rem_r, rem_s;
    logic [KID_W-1:0]    kid_r, kid_s;
    logic                en_r, en_s;
    logic                mode_r, mode_s;
    logic                snd_r, snd_s;
    logic                tone_r, tone_s;
    logic [TDIV_W-1:0]   tcnt_r, tcnt_s;
    logic                beep_r, beep_s;
    logic                busy_r, busy_s;
    logic [KEY_NUM-1:0]  press_s;
    logic                acc_s;
    logic [KID_W-1:0]    acc_id_s;

    // Press detection and lowest-index arbitration.
    always_comb begin
        press_s  = key_d0_r & ~bus.key_filter;
        acc_s    = 1'b0;
        acc_id_s = '0;
        // Scan downwards so the lowest pressed index is the last one written.
        for (int i = KEY_NUM - 1; i >= 0; i--) begin
            if (press_s[i]) begin
                acc_s    = 1'b1;
                acc_id_s = KID_W'(i);
            end else begin
                acc_s    = acc_s;
                acc_id_s = acc_id_s;
            end
        end
    end

    // FSM next state, burst bookkeeping and next output values.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        rem_s   = rem_r;
        kid_s   = kid_r;
        en_s    = en_r;
        mode_s  = mode_r;
        case (state_r)
            ST_IDLE: begin
                mode_s = bus.mode;
                if (mode_r == 1'b0) begin
                    if (acc_s) begin
                        en_s  = ~en_r;
                        kid_s = acc_id_s;
                    end else begin
                        en_s  = en_r;
                    end
                end else begin
                    if (acc_s) begin
                        rem_s   = REM_W'(acc_id_s) + REM_W'(1);
                        kid_s   = acc_id_s;
                        cnt_s   = '0;
                        state_s = ST_ON;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                // A mode switch always leaves the toggle buzzer off.
                if (mode_s != mode_r) begin
                    en_s = 1'b0;
                end else begin
                    en_s = en_s;
                end
            end
            ST_ON: begin
                if (cnt_r == ON_LAST) begin
                    cnt_s = '0;
                    if (rem_r > REM_W'(1)) begin
                        rem_s   = rem_r - REM_W'(1);
                        state_s = ST_OFF;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_OFF: begin
                if (cnt_r == OFF_LAST) begin
                    cnt_s   = '0;
                    state_s = ST_ON;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = '0;
            end
        endcase

        case (state_s)
            ST_ON:   snd_s = 1'b1;
            ST_OFF:  snd_s = 1'b0;
            ST_IDLE: snd_s = en_s & ~mode_s;
            default: snd_s = 1'b0;
        endcase
        busy_s = (state_s != ST_IDLE);

        // Tone divider: restart high on a rising snd, toggle every TONE_DIV clocks.
        if (snd_s == 1'b0) begin
            tone_s = 1'b0;
            tcnt_s = '0;
        end else if (snd_r == 1'b0) begin
            tone_s = 1'b1;
            tcnt_s = '0;
        end else if (tcnt_r == TDIV_LAST) begin
            tone_s = ~tone_r;
            tcnt_s = '0;
        end else begin
            tone_s = tone_r;
            tcnt_s = tcnt_r + TDIV_W'(1);
        end

        if (TONE_DIV == 0) begin
            beep_s = snd_s;
        end else begin
            beep_s = tone_s;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_r  <= ST_IDLE;
            key_d0_r <= '1;
            cnt_r    <= '0;
            rem_r    <= '0;
            kid_r    <= '0;
            en_r     <= 1'b0;
            mode_r   <= 1'b0;
            snd_r    <= 1'b0;
            tone_r   <= 1'b0;
            tcnt_r   <= '0;
            beep_r   <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            key_d0_r <= bus.key_filter;
            cnt_r    <= cnt_s;
            rem_r    <= rem_s;
            kid_r    <= kid_s;
            en_r     <= en_s;
            mode_r   <= mode_s;
            snd_r    <= snd_s;
            tone_r   <= tone_s;
            tcnt_r   <= tcnt_s;
            beep_r   <= beep_s;
            busy_r   <= busy_s;
        end
    end

    assign bus.beep   = beep_r;
    assign bus.busy   = busy_r;
    assign bus.key_id = kid_r;
endmodule

// File: tb/tb_key_beep_seq.sv
// tb_key_beep_seq: self-checking bench for key_beep_seq.
// Two instances share stimulus: dut0 (level output) and dut1 (TONE_DIV = 2).
// A table of toggle-mode vectors, directed burst/tone/reset sequences and a
// randomized run compared against a cycle-level behavioural model.
module tb_key_beep_seq;
    localparam int ON  = 4;
    localparam int OFF = 3;
    localparam int TD  = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] kf;
    logic       md;
    int         n_chk  = 0;
    int         n_fail = 0;

    key_beep_seq_if #(.KEY_NUM(4)) if0 ();
    key_beep_seq_if #(.KEY_NUM(4)) if1 ();

    assign if0.key_filter = kf;
    assign if0.mode       = md;
    assign if1.key_filter = kf;
    assign if1.mode       = md;

    key_beep_seq #(.KEY_NUM(4), .ON_CYC(ON), .OFF_CYC(OFF), .TONE_DIV(0)) dut0 (
        .sys_clk(clk), .sys_rst_n(rst_n), .bus(if0));
    key_beep_seq #(.KEY_NUM(4), .ON_CYC(ON), .OFF_CYC(OFF), .TONE_DIV(TD)) dut1 (
        .sys_clk(clk), .sys_rst_n(rst_n), .bus(if1));

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- table-driven toggle-mode vectors ----------------
    typedef struct {
        logic       rst_n;
        logic [3:0] kf;
        logic       md;
        int         reps;
        logic       beep;
        logic       busy;
        int         kid;
    } vec_t;

    vec_t tbl[$];

    // ---------------- burst sequence helper ----------------
    // Applies pkf for one edge, then observes the whole burst.
    // press_at/mode0_at (>=0) inject a key-0 press / mode=0 during the burst.
    task automatic run_burst(input string nm, input logic [3:0] pkf, input int ekid,
                             input int nb, input int press_at, input int mode0_at);
        int total;
        total = nb * ON + (nb - 1) * OFF;
        kf = pkf;
        tick();
        for (int t = 0; t < total; t++) begin
            int p;
            p = t % (ON + OFF);
            chk($sformatf("%s busy t=%0d", nm, t), int'(if0.busy), 1);
            chk($sformatf("%s beep t=%0d", nm, t), int'(if0.beep), (p < ON) ? 1 : 0);
            chk($sformatf("%s tone t=%0d", nm, t), int'(if1.beep),
                ((p < ON) && (((p / TD) % 2) == 0)) ? 1 : 0);
            chk($sformatf("%s kid t=%0d", nm, t), int'(if0.key_id), ekid);
            if (press_at >= 0 && t >= press_at) kf = 4'b1110;
            else kf = 4'hF;
            if (mode0_at >= 0 && t >= mode0_at) md = 1'b0;
            tick();
        end
        chk({nm, " busy end"}, int'(if0.busy), 0);
        chk({nm, " beep end"}, int'(if0.beep), 0);
        chk({nm, " tone end"}, int'(if1.beep), 0);
        chk({nm, " kid end"}, int'(if0.key_id), ekid);
    endtask

    // ---------------- behavioural reference model ----------------
    logic [3:0] m_d0;
    logic       m_mode, m_en, m_snd, m_busy;
    int         m_t, m_total, m_kid, m_run;

    task automatic model_step();
        logic [3:0] pr;
        int         id;
        logic       chg;
        if (!rst_n) begin
            m_d0 = 4'hF; m_mode = 1'b0; m_en = 1'b0; m_t = -1; m_total = 0;
            m_kid = 0; m_snd = 1'b0; m_busy = 1'b0; m_run = 0;
        end else begin
            pr = m_d0 & ~kf;
            m_d0 = kf;
            id = -1;
            for (int k = 3; k >= 0; k--) if (pr[k]) id = k;
            if (m_t >= 0) begin
                m_t++;
                if (m_t >= m_total) m_t = -1;
            end else begin
                chg = (md != m_mode);
                if (id >= 0) begin
                    m_kid = id;
                    if (m_mode) begin
                        m_t = 0;
                        m_total = (id + 1) * ON + id * OFF;
                    end else begin
                        m_en = ~m_en;
                    end
                end
                m_mode = md;
                if (chg) m_en = 1'b0;
            end
            m_busy = (m_t >= 0);
            m_snd  = m_busy ? ((m_t % (ON + OFF)) < ON) : (m_en & ~m_mode);
            m_run  = m_snd ? m_run + 1 : 0;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        kf    = 4'hF;
        md    = 1'b0;

        // Toggle mode: key 2 pressed twice 20 clocks apart, held, then key 1,
        // then a mode change that must clear the toggle state.
        tbl.push_back('{1'b0, 4'hF,    1'b0, 1,  1'b0, 1'b0, 0});
        tbl.push_back('{1'b1, 4'hF,    1'b0, 2,  1'b0, 1'b0, 0});
        tbl.push_back('{1'b1, 4'b1011, 1'b0, 1,  1'b1, 1'b0, 2});
        tbl.push_back('{1'b1, 4'b1011, 1'b0, 10, 1'b1, 1'b0, 2});
        tbl.push_back('{1'b1, 4'hF,    1'b0, 9,  1'b1, 1'b0, 2});
        tbl.push_back('{1'b1, 4'b1011, 1'b0, 1,  1'b0, 1'b0, 2});
        tbl.push_back('{1'b1, 4'b1011, 1'b0, 5,  1'b0, 1'b0, 2});
        tbl.push_back('{1'b1, 4'hF,    1'b0, 2,  1'b0, 1'b0, 2});
        tbl.push_back('{1'b1, 4'b1101, 1'b0, 1,  1'b1, 1'b0, 1});
        tbl.push_back('{1'b1, 4'hF,    1'b1, 1,  1'b0, 1'b0, 1});
        tbl.push_back('{1'b1, 4'hF,    1'b1, 2,  1'b0, 1'b0, 1});

        for (int v = 0; v < tbl.size(); v++) begin
            for (int r = 0; r < tbl[v].reps; r++) begin
                rst_n = tbl[v].rst_n;
                kf    = tbl[v].kf;
                md    = tbl[v].md;
                tick();
                chk($sformatf("tbl%0d.%0d beep", v, r), int'(if0.beep), int'(tbl[v].beep));
                chk($sformatf("tbl%0d.%0d busy", v, r), int'(if0.busy), int'(tbl[v].busy));
                chk($sformatf("tbl%0d.%0d kid", v, r), int'(if0.key_id), tbl[v].kid);
            end
        end

        // Burst mode (mode_q already 1): key 3 -> 4 beeps, 25 busy clocks.
        run_burst("burst_k3", 4'b0111, 3, 4, -1, -1);
        // Simultaneous edges on keys 1 and 3: key 1 wins, 2 beeps.
        run_burst("simul_k1k3", 4'b0101, 1, 2, -1, -1);
        // Key 0 pressed and mode set to 0 during a key-2 burst.
        run_burst("mid_burst", 4'b1011, 2, 3, 5, 8);
        tick();
        chk("post_burst beep", int'(if0.beep), 0);
        chk("post_burst kid", int'(if0.key_id), 2);
        kf = 4'hF;
        tick();
        kf = 4'b1101;
        tick();
        chk("toggle_after beep", int'(if0.beep), 1);
        chk("toggle_after busy", int'(if0.busy), 0);
        chk("toggle_after kid", int'(if0.key_id), 1);
        kf = 4'hF;
        md = 1'b1;
        tick();
        chk("mode1 clears beep", int'(if0.beep), 0);
        tick();

        // Tone pattern on key 0, then an immediate back-to-back burst.
        run_burst("tone_k0", 4'b1110, 0, 1, -1, -1);
        run_burst("b2b_k0", 4'b1110, 0, 1, -1, -1);

        // Reset at the 2nd ON clock, key 2 held low through reset release.
        kf = 4'b0111;
        tick();
        chk("rst_pre busy", int'(if0.busy), 1);
        rst_n = 1'b0;
        md    = 1'b0;
        kf    = 4'b1011;
        tick();
        chk("rst beep", int'(if0.beep), 0);
        chk("rst tone", int'(if1.beep), 0);
        chk("rst busy", int'(if0.busy), 0);
        chk("rst kid", int'(if0.key_id), 0);
        rst_n = 1'b1;
        tick();
        chk("rst_rel beep", int'(if0.beep), 1);
        chk("rst_rel busy", int'(if0.busy), 0);
        chk("rst_rel kid", int'(if0.key_id), 2);
        tick();
        chk("rst_hold beep", int'(if0.beep), 1);
        kf = 4'hF;

        // Randomized run against the behavioural model.
        rst_n = 1'b0;
        tick();
        model_step();
        for (int c = 0; c < 4000; c++) begin
            rst_n = ($urandom_range(299) != 0);
            for (int k = 0; k < 4; k++) if ($urandom_range(7) == 0) kf[k] = ~kf[k];
            if ($urandom_range(39) == 0) md = ~md;
            tick();
            model_step();
            chk($sformatf("rnd%0d beep", c), int'(if0.beep), int'(m_snd));
            chk($sformatf("rnd%0d busy", c), int'(if0.busy), int'(m_busy));
            chk($sformatf("rnd%0d kid", c), int'(if0.key_id), m_kid);
            chk($sformatf("rnd%0d tone", c), int'(if1.beep),
                (m_snd && ((((m_run - 1) / TD) % 2) == 0)) ? 1 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/key_beep_seq.md
# key_beep_seq

Multi-key buzzer sequencer: successor to the single-key toggle beeper. Watches KEY_NUM debounced, active-low key lines (outputs of the key filters). In toggle mode any press flips the buzzer on/off. In burst mode, key i plays i+1 timed beeps. Drives either an active buzzer (level) or a passive buzzer (square-wave tone) directly from the top level.

## Interface
- KEY_NUM, 4: number of key channels; 1..8.
- ON_CYC, 10_000_000: beep-on phase length in clocks; ≥1.
- OFF_CYC, 5_000_000: gap between beeps in clocks; ≥1.
- TONE_DIV, 0: 0 = level output (active buzzer); >0 = beep toggles every TONE_DIV clocks while sounding (passive buzzer).
- sys_clk  in  1  system clock; single clock domain.
- sys_rst_n  in  1  reset; synchronous, active-low.
- key_filter  in  KEY_NUM  debounced keys; falling edge = press.
- mode  in  1  0 = toggle, 1 = burst.
- beep  out  1  buzzer drive.
- busy  out  1  burst in progress.
- key_id  out  $clog2(KEY_NUM) (min 1)  index of last accepted press.

## Operation
- Edge detect: key_d0 register (reset all ones) delays key_filter by one clock. press[i] = key_d0[i] & ~key_filter[i].
- Arbitration: when several press bits are set in one cycle, only the lowest index is accepted; the others are discarded.
- Sounding: the internal signal snd is the logical "buzzer on" state.
  - TONE_DIV=0: beep = snd.
  - TONE_DIV>0: a tone divider restarts with beep=1 when snd rises, toggles beep every TONE_DIV clocks while snd=1, and forces beep=0 when snd=0.
- Mode register mode_q is loaded from mode only in IDLE. A change of mode_q clears the toggle enable en_q.
- FSM states: IDLE, ON, OFF.
  - IDLE, mode_q=0: an accepted press flips en_q and loads key_id. snd=en_q. busy=0.
  - IDLE, mode_q=1: snd=0. An accepted press of key i loads rem=i+1, loads key_id=i, clears the phase counter, and moves to ON.
  - ON: snd=1, busy=1. The counter runs 0..ON_CYC-1.
    - At terminal count with rem>1: decrement rem and go to OFF.
    - At terminal count with rem=1: go to IDLE.
  - OFF: snd=0, busy=1. The counter runs 0..OFF_CYC-1. At terminal count go to ON.
- Presses in ON/OFF are ignored and not queued. mode changes during a burst take effect in IDLE.
- Counter width: $clog2(max(ON_CYC,OFF_CYC)). rem width: $clog2(KEY_NUM+1).

## Timing
- Reset values: beep=0, busy=0, key_id=0, en_q=0, mode_q=0, state=IDLE, key_d0=all ones.
- Reset release with a key held low: that key counts as one press on the first post-reset edge.
- Press latency: key_filter[i] low at edge k with key_d0[i]=1 gives snd/busy/key_id updated at edge k, visible one cycle after the input change.
- Burst timing: beep is high exactly ON_CYC clocks per beep and low exactly OFF_CYC clocks between beeps.
  - Total busy time for key i: (i+1)·ON_CYC + i·OFF_CYC clocks.
  - busy and beep fall on the same edge after the last ON phase.
- Back-to-back: a press accepted on the first IDLE cycle after a burst starts a new burst with no extra gap.
- Mid-operation reset: a synchronous reset during ON/OFF returns all outputs to reset values on that edge. No residual beep.

## Test plan
Parameters for all scenarios: KEY_NUM=4, ON_CYC=4, OFF_CYC=3, TONE_DIV=0 unless stated.

- Toggle mode: press key 2 twice, 20 clocks apart.
  - After the first press: beep=1, key_id=2, busy=0.
  - After the second press: beep=0.
  - Holding the key low produces no further toggles.
- Burst mode: press key 3.
  - busy high 25 clocks.
  - beep pattern 4×(4 high, 3 low), with the trailing low gap omitted.
  - key_id=3.
- Simultaneous falling edges on keys 1 and 3 in burst mode: exactly 2 beeps, key_id=1.
- Press during a burst and mode change during a burst:
  - Key 0 pressed mid-burst: ignored.
  - mode set to 0 mid-burst: burst completes, then toggle mode is active with beep=0.
- Tone: TONE_DIV=2, press key 0 in burst mode.
  - beep = 1,1,0,0 across the 4 ON clocks.
  - beep=0 afterwards, busy=0.
- Reset asserted at the 2nd ON clock: beep=0, busy=0, key_id=0 on that edge. A key held low through reset release triggers one press.
